// File: rtl/hog_norm_sched.sv
// Frame scheduler ahead of the HOG block normalizer: buffers cell histograms,
// paces their issue at least GAP cycles apart and tracks returned features per frame.
module hog_norm_sched #(
  parameter int unsigned BIN_W    = 20,
  parameter int unsigned CELL_NUM = 1200,
  parameter int unsigned LINE     = 40,
  parameter int unsigned GAP      = 48,
  parameter int unsigned FIFO_D   = 4,
  parameter int unsigned DRAIN_TO = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9*BIN_W-1:0] s_bin,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [9*BIN_W-1:0] m_bin,
  output logic               m_valid,
  input  logic               fea_valid,
  output logic               frame_done,
  output logic               frame_err,
  output logic [15:0]        feat_cnt,
  output logic               busy
);

  localparam int unsigned DW        = 9 * BIN_W;
  localparam int unsigned AW        = $clog2(FIFO_D);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned IW        = $clog2(CELL_NUM + 1);
  localparam int unsigned GW        = $clog2(GAP);
  localparam int unsigned TW        = $clog2(DRAIN_TO + 1);
  localparam int unsigned EXP_FEA_I = (CELL_NUM / LINE - 1) * (LINE - 1) * 36;
  localparam logic [15:0] EXP_FEA   = 16'(EXP_FEA_I);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem [FIFO_D];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s_ready_q;
  logic [DW-1:0]   m_bin_q;
  logic            m_valid_q;
  logic [IW-1:0]   issued_q, issued_d, issued_inc;
  logic [GW-1:0]   gap_q, gap_d, gap_dec;
  logic [TW-1:0]   idle_q, idle_d;
  logic [15:0]     feat_q, feat_d;
  logic            err_q, err_d;
  logic            done_q, busy_q;
  logic            push, pop, empty;

  assign push  = s_valid && s_ready_q;
  assign pop   = (state_q == S_ISSUE);
  assign empty = (cnt_q == CW'(0));

  // Next-state, frame counters and FIFO occupancy
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    gap_d      = gap_q;
    idle_d     = idle_q;
    err_d      = err_q;
    feat_d     = feat_q;
    cnt_d      = cnt_q;
    issued_inc = issued_q + IW'(1);
    gap_dec    = (gap_q == GW'(0)) ? GW'(0) : gap_q - GW'(1);

    if (state_q != S_IDLE && fea_valid && feat_q != 16'hFFFF)
      feat_d = feat_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d  = S_ISSUE;
          issued_d = IW'(0);
          feat_d   = 16'd0;
          err_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        issued_d = issued_inc;
        gap_d    = GW'(GAP - 1);
        idle_d   = TW'(0);
        state_d  = (issued_inc == IW'(CELL_NUM)) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        gap_d = gap_dec;
        if (gap_dec == GW'(0) && !empty) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (feat_q == EXP_FEA) begin
          state_d = S_DONE;
        end else if (fea_valid) begin
          idle_d = TW'(0);
        end else if (idle_q == TW'(DRAIN_TO - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b1;
      m_bin_q   <= '0;
      m_valid_q <= 1'b0;
      issued_q  <= '0;
      gap_q     <= '0;
      idle_q    <= '0;
      feat_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= (cnt_d != CW'(FIFO_D));
      m_valid_q <= pop;
      issued_q  <= issued_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      feat_q    <= feat_d;
      err_q     <= err_d;
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        m_bin_q  <= mem[rd_ptr_q];
      end
    end
  end

  // Cell storage carries no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= s_bin;
  end

  assign s_ready    = s_ready_q;
  assign m_bin      = m_bin_q;
  assign m_valid    = m_valid_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign feat_cnt   = feat_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hog_norm_sched.sv
// Directed bench for hog_norm_sched at reduced frame size (8 cells, EXP_FEA=108).
module tb_hog_norm_sched;

  localparam int unsigned BIN_W    = 20;
  localparam int unsigned CELL_NUM = 8;
  localparam int unsigned LINE     = 4;
  localparam int unsigned GAP      = 6;
  localparam int unsigned FIFO_D   = 4;
  localparam int unsigned DRAIN_TO = 10;
  localparam int unsigned DW       = 9 * BIN_W;
  localparam int          EXP_FEA  = 108;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_bin = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_bin;
  logic          m_valid;
  logic          fea_valid = 1'b0;
  logic          frame_done;
  logic          frame_err;
  logic [15:0]   feat_cnt;
  logic          busy;

  hog_norm_sched #(
    .BIN_W(BIN_W), .CELL_NUM(CELL_NUM), .LINE(LINE),
    .GAP(GAP), .FIFO_D(FIFO_D), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .clk(clk), .rst(rst), .s_bin(s_bin), .s_valid(s_valid), .s_ready(s_ready),
    .m_bin(m_bin), .m_valid(m_valid), .fea_valid(fea_valid),
    .frame_done(frame_done), .frame_err(frame_err), .feat_cnt(feat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observation just after each rising edge
  int            cyc = 0;
  int            mv_cnt = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            refused_cnt = 0;
  int            sr_low_cnt = 0;
  logic          sr_prev = 1'b1;
  logic [DW-1:0] got_q [$];
  int            mv_cyc [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_valid === 1'b1) begin
      mv_cnt++;
      got_q.push_back(m_bin);
      mv_cyc.push_back(cyc);
      if (s_valid === 1'b1 && sr_prev === 1'b0) refused_cnt++;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_ready === 1'b0) sr_low_cnt++;
    sr_prev = s_ready;
  end

  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] mk_bin(input int k);
    logic [DW-1:0] r;
    for (int b = 0; b < 9; b++) r[b*BIN_W +: BIN_W] = 20'(k * 16 + b + 1);
    return r;
  endfunction

  task automatic push_cell(input int k, output bit ok);
    int guard = 0;
    s_bin   = mk_bin(k);
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok = (s_ready === 1'b1);
    if (ok) begin
      @(negedge clk);
      exp_q.push_back(mk_bin(k));
    end
  endtask

  task automatic push_burst(input int first, input int n, output bit ok);
    bit o;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      push_cell(first + k, o);
      ok &= o;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_fea(input int n);
    for (int i = 0; i < n; i++) begin
      fea_valid = 1'b1;
      @(negedge clk);
    end
    fea_valid = 1'b0;
  endtask

  task automatic wait_mv(input int target, output bit ok);
    int guard = 0;
    while (mv_cnt < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    ok = (mv_cnt >= target);
  endtask

  task automatic wait_done(input int target, output bit ok);
    int guard = 0;
    while (done_cnt < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic test_reset();
    bit ok, tok;
    int mb;
    tok = 1'b1;
    mb  = mv_cnt;
    push_burst(100, 3, ok); tok &= ok;
    wait_mv(mb + 1, ok);    tok &= ok;
    send_fea(5);
    n_vec++; if (feat_cnt !== 16'd5) begin n_err++; $display("FAIL rst_pre_feat: got %0d expected 5", feat_cnt); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (feat_cnt !== 16'd0) begin n_err++; $display("FAIL rst_feat_cnt: got %0d expected 0", feat_cnt); end
    n_vec++; if (frame_err !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL rst_flags: got err=%b done=%b expected 0 0", frame_err, frame_done); end
    n_vec++; if (m_bin !== '0) begin n_err++; $display("FAIL rst_m_bin: got %h expected 0", m_bin); end
    mb = mv_cnt;
    send_fea(3);
    repeat (10) @(negedge clk);
    n_vec++; if (mv_cnt !== mb) begin n_err++; $display("FAIL rst_fifo_empty: got %0d issues expected 0", mv_cnt - mb); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    n_vec++; if (feat_cnt !== 16'd0) begin n_err++; $display("FAIL rst_idle_fea_ignored: got %0d expected 0", feat_cnt); end
    n_vec++; if (!tok) begin n_err++; $display("FAIL rst_timeout: got timeout expected progress"); end
  endtask

  task automatic test_back_to_back();
    bit ok, tok;
    int gb, eb, mb, db, sb;
    tok = 1'b1;
    gb = got_q.size(); eb = exp_q.size(); mb = mv_cnt; db = done_cnt; sb = sr_low_cnt;
    push_burst(0, 8, ok);   tok &= ok;
    wait_mv(mb + 8, ok);    tok &= ok;
    send_fea(EXP_FEA);
    wait_done(db + 1, ok);  tok &= ok;
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_done_hi: got %b expected 1", frame_done); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL b2b_err: got %b expected 0", frame_err); end
    n_vec++; if (feat_cnt !== 16'(EXP_FEA)) begin n_err++; $display("FAIL b2b_feat_cnt: got %0d expected %0d", feat_cnt, EXP_FEA); end
    repeat (4) @(negedge clk);
    n_vec++; if (done_cnt !== db + 1) begin n_err++; $display("FAIL b2b_done_once: got %0d pulses expected 1", done_cnt - db); end
    n_vec++; if (busy !== 1'b0 || feat_cnt !== 16'(EXP_FEA)) begin n_err++; $display("FAIL b2b_idle_hold: got busy=%b feat=%0d expected 0 %0d", busy, feat_cnt, EXP_FEA); end
    n_vec++; if (sr_low_cnt <= sb) begin n_err++; $display("FAIL b2b_s_ready_low: got %0d low cycles expected >0", sr_low_cnt - sb); end
    for (int i = 1; i < 8 && tok; i++) begin
      n_vec++;
      if (mv_cyc[gb+i] - mv_cyc[gb+i-1] !== int'(GAP)) begin
        n_err++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, mv_cyc[gb+i] - mv_cyc[gb+i-1], GAP);
      end
    end
    for (int i = 0; i < 8 && tok; i++) begin
      n_vec++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    n_vec++; if (!tok) begin n_err++; $display("FAIL b2b_timeout: got timeout expected progress"); end
  endtask

  task automatic test_slow_feed();
    bit ok, tok;
    int gb, eb, mb, db;
    tok = 1'b1;
    gb = got_q.size(); eb = exp_q.size(); mb = mv_cnt; db = done_cnt;
    for (int k = 0; k < 7; k++) begin
      push_burst(20 + k, 1, ok); tok &= ok;
      repeat (19) @(negedge clk);
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL slow_wait_busy: got %b expected 1", busy); end
    n_vec++; if (mv_cnt !== mb + 7) begin n_err++; $display("FAIL slow_issued7: got %0d expected 7", mv_cnt - mb); end
    push_burst(27, 1, ok);  tok &= ok;
    wait_mv(mb + 8, ok);    tok &= ok;
    send_fea(EXP_FEA);
    wait_done(db + 1, ok);  tok &= ok;
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL slow_err: got %b expected 0", frame_err); end
    n_vec++; if (feat_cnt !== 16'(EXP_FEA)) begin n_err++; $display("FAIL slow_feat_cnt: got %0d expected %0d", feat_cnt, EXP_FEA); end
    for (int i = 1; i < 8 && tok; i++) begin
      n_vec++;
      if (mv_cyc[gb+i] - mv_cyc[gb+i-1] !== 20) begin
        n_err++; $display("FAIL slow_gap%0d: got %0d expected 20", i, mv_cyc[gb+i] - mv_cyc[gb+i-1]);
      end
    end
    for (int i = 0; i < 8 && tok; i++) begin
      n_vec++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin n_err++; $display("FAIL slow_data%0d: got %h expected %h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    n_vec++; if (!tok) begin n_err++; $display("FAIL slow_timeout: got timeout expected progress"); end
  endtask

  task automatic test_drain_timeout();
    bit ok, tok;
    int mb, db, t0;
    tok = 1'b1;
    mb = mv_cnt; db = done_cnt;
    push_burst(30, 8, ok);  tok &= ok;
    wait_mv(mb + 8, ok);    tok &= ok;
    send_fea(100);
    t0 = cyc;
    wait_done(db + 1, ok);  tok &= ok;
    n_vec++; if (done_cyc - t0 !== int'(DRAIN_TO)) begin n_err++; $display("FAIL to_latency: got %0d expected %0d", done_cyc - t0, DRAIN_TO); end
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b expected 1", frame_err); end
    n_vec++; if (feat_cnt !== 16'd100) begin n_err++; $display("FAIL to_feat_cnt: got %0d expected 100", feat_cnt); end
    @(negedge clk);
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL to_done_pulse: got %b expected 0", frame_done); end
    repeat (3) @(negedge clk);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky: got %b expected 1", frame_err); end
    n_vec++; if (!tok) begin n_err++; $display("FAIL to_timeout: got timeout expected progress"); end
  endtask

  task automatic test_full_pop();
    bit ok, tok;
    int gb, eb, mb, db, rb;
    tok = 1'b1;
    gb = got_q.size(); eb = exp_q.size(); mb = mv_cnt; db = done_cnt; rb = refused_cnt;
    push_burst(50, 8, ok);  tok &= ok;
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL fp_err_cleared: got %b expected 0", frame_err); end
    wait_mv(mb + 8, ok);    tok &= ok;
    send_fea(EXP_FEA);
    wait_done(db + 1, ok);  tok &= ok;
    n_vec++; if (refused_cnt <= rb) begin n_err++; $display("FAIL fp_refused: got %0d refusals expected >0", refused_cnt - rb); end
    n_vec++; if (mv_cnt !== mb + 8) begin n_err++; $display("FAIL fp_issue_cnt: got %0d expected 8", mv_cnt - mb); end
    for (int i = 0; i < 8 && tok; i++) begin
      n_vec++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin n_err++; $display("FAIL fp_data%0d: got %h expected %h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    n_vec++; if (!tok) begin n_err++; $display("FAIL fp_timeout: got timeout expected progress"); end
  endtask

  task automatic test_drain_push();
    bit ok, tok;
    int gb, mb, db;
    tok = 1'b1;
    gb = got_q.size(); mb = mv_cnt; db = done_cnt;
    push_burst(70, 8, ok);  tok &= ok;
    wait_mv(mb + 8, ok);    tok &= ok;
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL dp_s_ready: got %b expected 1", s_ready); end
    push_burst(99, 1, ok);  tok &= ok;
    send_fea(100);
    wait_done(db + 1, ok);  tok &= ok;
    n_vec++; if (mv_cnt !== mb + 8) begin n_err++; $display("FAIL dp_held: got %0d issues expected 8", mv_cnt - mb); end
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL dp_err_set: got %b expected 1", frame_err); end
    wait_mv(mb + 9, ok);    tok &= ok;
    n_vec++; if (tok && got_q[gb+8] !== mk_bin(99)) begin n_err++; $display("FAIL dp_next_first: got %h expected %h", got_q[gb+8], mk_bin(99)); end
    n_vec++; if (tok && mv_cyc[gb+8] <= done_cyc) begin n_err++; $display("FAIL dp_order: got issue@%0d expected after done@%0d", mv_cyc[gb+8], done_cyc); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL dp_err_cleared: got %b expected 0", frame_err); end
    n_vec++; if (feat_cnt !== 16'd0 || busy !== 1'b1) begin n_err++; $display("FAIL dp_new_frame: got feat=%0d busy=%b expected 0 1", feat_cnt, busy); end
    n_vec++; if (!tok) begin n_err++; $display("FAIL dp_timeout: got timeout expected progress"); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_slow_feed();
    test_drain_timeout();
    test_full_pop();
    test_drain_push();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
